ahb_sram_ctrl: RTL and testbench

AHB-Lite slave that terminates the core's AHB master port (a_haddr/a_htrans/...) and drives one single-port synchronous SRAM macro. Sits directly downstream of the cpu_core AHB master, behind the address decoder that generates hsel. Handles the AHB address/data phase pipeline, byte lanes, programmable read wait states, read-after-write port conflicts and two-cycle ERROR responses.

---
 rtl/ahb_sram_ctrl_pkg.sv | 30 +++
 rtl/ahb_sram_ctrl_if.sv | 31 +++
 rtl/ahb_sram_be_gen.sv | 31 +++
 rtl/ahb_sram_ctrl.sv | 147 ++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_ctrl_pkg.sv
// Shared encodings for the AHB-Lite SRAM controller: bus field codes and FSM states.
// No logic, so no latency.
// No handshake of its own.
package ahb_sram_ctrl_pkg;

    // Bus widths taken from the system-wide AHB configuration
    localparam int AHB_ADDR_WIDTH = 32;
    localparam int AHB_DATA_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Controller states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR       = 3'd1;
    localparam logic [2:0] ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_ERR1     = 3'd4;
    localparam logic [2:0] ST_ERR2     = 3'd5;

endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite bus bundle between the core master and the SRAM controller slave.
// Pure wiring, no latency.
// Stalls are carried by hreadyout/hready.
interface ahb_sram_ctrl_if
    import ahb_sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH = AHB_DATA_WIDTH
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/ahb_sram_be_gen.sv
// Little-endian byte-lane enables and alignment/size check for one AHB transfer.
// Purely combinational, zero latency.
// No backpressure.
module ahb_sram_be_gen
    import ahb_sram_ctrl_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] be_o,
    output logic       align_err_o
);

    // Decode size/offset into lanes; unsupported sizes flag an error with no lanes
    always_comb begin
        be_o        = 4'b0000;
        align_err_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
            HSIZE_HALF: begin
                be_o        = 4'b0011 << addr_lo_i;
                align_err_o = addr_lo_i[0];
            end
            HSIZE_WORD: begin
                be_o        = 4'b1111;
                align_err_o = (addr_lo_i != 2'b00);
            end
            default:    align_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave driving one single-port synchronous SRAM.
// Writes zero-wait; reads 1+RD_WAIT cycles (2+RD_WAIT right after a write); errors 2 cycles.
// Stalls the master with hreadyout=0 during read waits, delayed read issue and ERR1.
module ahb_sram_ctrl
    import ahb_sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH = AHB_DATA_WIDTH,
    parameter int MEM_AW     = 12,
    parameter int RD_WAIT    = 0
)(
    input  logic                    clk,
    input  logic                    rst,
    ahb_sram_ctrl_if.slave          bus,
    output logic                    sram_cs,
    output logic                    sram_we,
    output logic [DATA_WIDTH/8-1:0] sram_be,
    output logic [MEM_AW-1:0]       sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata
);

    localparam logic [2:0] RD_WAIT_L = 3'(RD_WAIT);

    logic [2:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [MEM_AW-1:0]     addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic                  rdv_q;
    logic [DATA_WIDTH-1:0] hrdata_q;

    logic [3:0] be_new;
    logic       align_err;
    logic       range_err;
    logic       accept;
    logic       last_rd;
    logic       done;
    logic       take;
    logic       rd_now;

    // hburst carries no meaning here: bursts are handled as single accesses
    logic unused_hburst;
    assign unused_hburst = ^bus.hburst;

    ahb_sram_be_gen u_be_gen (
        .hsize_i     (bus.hsize),
        .addr_lo_i   (bus.haddr[1:0]),
        .be_o        (be_new),
        .align_err_o (align_err)
    );

    assign range_err = |bus.haddr[ADDR_WIDTH-1:MEM_AW+2];
    assign accept    = bus.hsel & bus.hready & bus.htrans[1] & ~rst;
    assign last_rd   = (cnt_q == RD_WAIT_L);
    // Cycles in which the current data phase completes and a new address phase is taken
    assign done      = (state_q == ST_IDLE) || (state_q == ST_WR) || (state_q == ST_ERR2) ||
                       ((state_q == ST_RD_WAIT) && last_rd);
    assign take      = accept & done;
    // Port is free unless a write data phase occupies it this cycle
    assign rd_now    = take & ~(align_err | range_err) & ~bus.hwrite & (state_q != ST_WR);

    // Next-state: sequencing within a data phase, then the new address phase on completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        case (state_q)
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
                cnt_d   = 3'd0;
            end
            ST_RD_WAIT:  if (!last_rd) cnt_d = cnt_q + 3'd1;
            ST_ERR1:     state_d = ST_ERR2;
            default:     ;
        endcase
        if (done) begin
            state_d = ST_IDLE;
            if (take) begin
                if (align_err | range_err) begin
                    state_d = ST_ERR1;
                end else begin
                    addr_d = bus.haddr[MEM_AW+1:2];
                    cnt_d  = 3'd0;
                    if (bus.hwrite) begin
                        state_d = ST_WR;
                        be_d    = be_new;
                    end else if (state_q == ST_WR) begin
                        state_d = ST_RD_ISSUE;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
        end
    end

    // SRAM strobes: write data phase, deferred read, or same-cycle read on a free port
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (!rst) begin
            if (state_q == ST_WR) begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_be    = be_q;
                sram_addr  = addr_q;
                sram_wdata = bus.hwdata;
            end else if (state_q == ST_RD_ISSUE) begin
                sram_cs   = 1'b1;
                sram_addr = addr_q;
            end else if (rd_now) begin
                sram_cs   = 1'b1;
                sram_addr = bus.haddr[MEM_AW+1:2];
            end
        end
    end

    // State, captured address phase and read-data holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= '0;
            be_q     <= 4'b0000;
            rdv_q    <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            rdv_q   <= sram_cs & ~sram_we;
            if (rdv_q) hrdata_q <= sram_rdata;
        end
    end

    // SRAM data is passed through the cycle it returns, then held until the next read
    assign bus.hrdata    = rdv_q ? sram_rdata : hrdata_q;
    assign bus.hreadyout = ~((state_q == ST_RD_ISSUE) || (state_q == ST_ERR1) ||
                             ((state_q == ST_RD_WAIT) && !last_rd));
    assign bus.hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench: RD_WAIT=0 and RD_WAIT=3 controllers, each with a behavioural SRAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A single master stimulus is routed to whichever controller sel3 selects.
module tb_ahb_sram_ctrl;
    import ahb_sram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel3 = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = HSIZE_WORD;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int acc0  = 0;

    always #5 clk = ~clk;

    ahb_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    ahb_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    assign bus0.hsel = hsel & ~sel3;     assign bus3.hsel = hsel & sel3;
    assign bus0.haddr = haddr;           assign bus3.haddr = haddr;
    assign bus0.htrans = htrans;         assign bus3.htrans = htrans;
    assign bus0.hwrite = hwrite;         assign bus3.hwrite = hwrite;
    assign bus0.hsize = hsize;           assign bus3.hsize = hsize;
    assign bus0.hburst = hburst;         assign bus3.hburst = hburst;
    assign bus0.hwdata = hwdata;         assign bus3.hwdata = hwdata;
    assign bus0.hready = bus0.hreadyout; assign bus3.hready = bus3.hreadyout;

    logic        cs0, we0, cs3, we3;
    logic [3:0]  be0, be3;
    logic [11:0] addr0, addr3;
    logic [31:0] wdata0, wdata3, rdata0, rdata3;
    logic [31:0] mem0 [0:4095];
    logic [31:0] mem3 [0:4095];

    ahb_sram_ctrl #(.MEM_AW(12), .RD_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .sram_cs(cs0), .sram_we(we0), .sram_be(be0),
        .sram_addr(addr0), .sram_wdata(wdata0), .sram_rdata(rdata0)
    );
    ahb_sram_ctrl #(.MEM_AW(12), .RD_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .sram_cs(cs3), .sram_we(we3), .sram_be(be3),
        .sram_addr(addr3), .sram_wdata(wdata3), .sram_rdata(rdata3)
    );

    always @(posedge clk) begin
        if (cs0 && we0) for (int b = 0; b < 4; b++) if (be0[b]) mem0[addr0][b*8 +: 8] <= wdata0[b*8 +: 8];
        if (cs0 && !we0) rdata0 <= mem0[addr0];
        if (cs0) acc0 <= acc0 + 1;
    end
    always @(posedge clk) begin
        if (cs3 && we3) for (int b = 0; b < 4; b++) if (be3[b]) mem3[addr3][b*8 +: 8] <= wdata3[b*8 +: 8];
        if (cs3 && !we3) rdata3 <= mem3[addr3];
    end

    // Observed outputs of the selected controller
    logic        o_rdy, o_resp, o_cs, o_we;
    logic [31:0] o_rdata, o_wdata;
    logic [3:0]  o_be;
    logic [11:0] o_addr;
    assign o_rdy   = sel3 ? bus3.hreadyout : bus0.hreadyout;
    assign o_resp  = sel3 ? bus3.hresp : bus0.hresp;
    assign o_rdata = sel3 ? bus3.hrdata : bus0.hrdata;
    assign o_cs    = sel3 ? cs3 : cs0;
    assign o_we    = sel3 ? we3 : we0;
    assign o_be    = sel3 ? be3 : be0;
    assign o_addr  = sel3 ? addr3 : addr0;
    assign o_wdata = sel3 ? wdata3 : wdata0;

    task automatic step(input logic r, input logic s, input logic [31:0] a, input logic [1:0] t,
                        input logic w, input logic [2:0] sz, input logic [31:0] wd);
        @(posedge clk); #1;
        rst = r; hsel = s; haddr = a; htrans = t; hwrite = w; hsize = sz; hwdata = wd;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] wd);
        step(1'b0, 1'b0, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD, wd);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        step(1'b1, 1'b0, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        idle(32'h0);
        n_cmp++; if (o_rdy !== 1'b1) begin $display("FAIL rst_hreadyout got %b want 1", o_rdy); n_bad++; end
        n_cmp++; if (o_resp !== 1'b0) begin $display("FAIL rst_hresp got %b want 0", o_resp); n_bad++; end
        n_cmp++; if (o_rdata !== 32'h0) begin $display("FAIL rst_hrdata got %h want 0", o_rdata); n_bad++; end
        n_cmp++; if ({o_cs, o_we, o_be, o_addr, o_wdata} !== '0) begin
            $display("FAIL rst_sram got cs=%b we=%b be=%h addr=%h wd=%h want all 0", o_cs, o_we, o_be, o_addr, o_wdata); n_bad++; end
    endtask

    task automatic test_word_rw;
        step(1'b0, 1'b1, 32'h10, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0);
        n_cmp++; if (o_cs !== 1'b0) begin $display("FAIL wr_addrphase_cs got %b want 0", o_cs); n_bad++; end
        idle(32'hDEADBEEF);
        n_cmp++; if ({o_cs, o_we, o_be, o_addr, o_wdata, o_rdy} !== {1'b1, 1'b1, 4'hF, 12'h004, 32'hDEADBEEF, 1'b1}) begin
            $display("FAIL wr_dataphase got cs=%b we=%b be=%h addr=%h wd=%h rdy=%b want 1 1 f 004 deadbeef 1",
                     o_cs, o_we, o_be, o_addr, o_wdata, o_rdy); n_bad++; end
        step(1'b0, 1'b1, 32'h10, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        n_cmp++; if ({o_cs, o_we, o_addr} !== {1'b1, 1'b0, 12'h004}) begin
            $display("FAIL rd_strobe got cs=%b we=%b addr=%h want 1 0 004", o_cs, o_we, o_addr); n_bad++; end
        idle(32'h0);
        n_cmp++; if ({o_rdy, o_resp, o_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            $display("FAIL rd_data got rdy=%b resp=%b rdata=%h want 1 0 deadbeef", o_rdy, o_resp, o_rdata); n_bad++; end
    endtask

    task automatic test_byte_lanes;
        step(1'b0, 1'b1, 32'h13, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h0);
        step(1'b0, 1'b1, 32'h10, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'hAA000000);
        n_cmp++; if ({o_cs, o_we, o_be, o_addr, o_rdy} !== {1'b1, 1'b1, 4'b1000, 12'h004, 1'b1}) begin
            $display("FAIL byte_wr got cs=%b we=%b be=%b addr=%h rdy=%b want 1 1 1000 004 1", o_cs, o_we, o_be, o_addr, o_rdy); n_bad++; end
        idle(32'h0);
        n_cmp++; if ({o_rdy, o_cs, o_we, o_addr} !== {1'b0, 1'b1, 1'b0, 12'h004}) begin
            $display("FAIL raw_issue got rdy=%b cs=%b we=%b addr=%h want 0 1 0 004", o_rdy, o_cs, o_we, o_addr); n_bad++; end
        idle(32'h0);
        n_cmp++; if ({o_rdy, o_rdata} !== {1'b1, 32'hAAADBEEF}) begin
            $display("FAIL raw_data got rdy=%b rdata=%h want 1 aaadbeef", o_rdy, o_rdata); n_bad++; end
        idle(32'h0);
        n_cmp++; if (o_rdata !== 32'hAAADBEEF) begin $display("FAIL rdata_hold got %h want aaadbeef", o_rdata); n_bad++; end
    endtask

    task automatic test_errors;
        logic [31:0] eaddr [2];
        logic [2:0]  esize [2];
        eaddr[0] = 32'h4002; esize[0] = HSIZE_WORD;
        eaddr[1] = 32'h4000; esize[1] = HSIZE_BYTE;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, eaddr[k], HTRANS_NONSEQ, k[0], esize[k], 32'h0);
            n_cmp++; if (o_cs !== 1'b0) begin $display("FAIL err%0d_accept_cs got %b want 0", k, o_cs); n_bad++; end
            idle(32'h0);
            n_cmp++; if ({o_rdy, o_resp, o_cs} !== 3'b010) begin
                $display("FAIL err%0d_cyc1 got rdy=%b resp=%b cs=%b want 0 1 0", k, o_rdy, o_resp, o_cs); n_bad++; end
            idle(32'h0);
            n_cmp++; if ({o_rdy, o_resp, o_cs} !== 3'b110) begin
                $display("FAIL err%0d_cyc2 got rdy=%b resp=%b cs=%b want 1 1 0", k, o_rdy, o_resp, o_cs); n_bad++; end
            idle(32'h0);
            n_cmp++; if ({o_rdy, o_resp} !== 2'b10) begin
                $display("FAIL err%0d_after got rdy=%b resp=%b want 1 0", k, o_rdy, o_resp); n_bad++; end
        end
    endtask

    task automatic test_burst;
        int base;
        base = acc0;
        hburst = 3'b011;
        step(1'b0, 1'b1, 32'h20, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0);
        step(1'b0, 1'b1, 32'h24, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'hB0B0_0008);
        n_cmp++; if ({o_cs, o_we, o_addr, o_wdata, o_rdy} !== {1'b1, 1'b1, 12'd8, 32'hB0B0_0008, 1'b1}) begin
            $display("FAIL burst_b0 got cs=%b we=%b addr=%0d wd=%h rdy=%b want 1 1 8 b0b00008 1", o_cs, o_we, o_addr, o_wdata, o_rdy); n_bad++; end
        step(1'b0, 1'b1, 32'h28, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'hB0B0_0009);
        n_cmp++; if ({o_cs, o_addr, o_rdy} !== {1'b1, 12'd9, 1'b1}) begin
            $display("FAIL burst_b1 got cs=%b addr=%0d rdy=%b want 1 9 1", o_cs, o_addr, o_rdy); n_bad++; end
        step(1'b0, 1'b1, 32'h28, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF);
        n_cmp++; if ({o_cs, o_rdy, o_resp} !== 3'b010) begin
            $display("FAIL burst_busy got cs=%b rdy=%b resp=%b want 0 1 0", o_cs, o_rdy, o_resp); n_bad++; end
        step(1'b0, 1'b1, 32'h2C, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'hB0B0_000A);
        n_cmp++; if ({o_cs, o_addr, o_rdy} !== {1'b1, 12'd10, 1'b1}) begin
            $display("FAIL burst_b2 got cs=%b addr=%0d rdy=%b want 1 10 1", o_cs, o_addr, o_rdy); n_bad++; end
        hburst = 3'd0;
        idle(32'hB0B0_000B);
        n_cmp++; if ({o_cs, o_addr, o_rdy} !== {1'b1, 12'd11, 1'b1}) begin
            $display("FAIL burst_b3 got cs=%b addr=%0d rdy=%b want 1 11 1", o_cs, o_addr, o_rdy); n_bad++; end
        idle(32'h0);
        n_cmp++; if (acc0 - base !== 4) begin $display("FAIL burst_access_count got %0d want 4", acc0 - base); n_bad++; end
        for (int i = 8; i < 12; i++) begin
            n_cmp++; if (mem0[i] !== (32'hB0B0_0000 | 32'(i))) begin
                $display("FAIL burst_mem[%0d] got %h want %h", i, mem0[i], 32'hB0B0_0000 | 32'(i)); n_bad++; end
        end
    endtask

    task automatic test_rd_wait3;
        sel3 = 1'b1;
        step(1'b0, 1'b1, 32'h0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0);
        step(1'b0, 1'b1, 32'h4, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h1111_1111);
        idle(32'h2222_2222);
        step(1'b0, 1'b1, 32'h0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        n_cmp++; if ({o_cs, o_we, o_addr} !== {1'b1, 1'b0, 12'd0}) begin
            $display("FAIL w3_rd0_strobe got cs=%b we=%b addr=%0d want 1 0 0", o_cs, o_we, o_addr); n_bad++; end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h4, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
            n_cmp++; if (o_rdy !== 1'b0) begin $display("FAIL w3_rd0_wait%0d got rdy=%b want 0", i, o_rdy); n_bad++; end
        end
        step(1'b0, 1'b1, 32'h4, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        n_cmp++; if ({o_rdy, o_rdata, o_cs, o_addr} !== {1'b1, 32'h1111_1111, 1'b1, 12'd1}) begin
            $display("FAIL w3_rd0_done got rdy=%b rdata=%h cs=%b addr=%0d want 1 11111111 1 1", o_rdy, o_rdata, o_cs, o_addr); n_bad++; end
        for (int i = 0; i < 3; i++) begin
            idle(32'h0);
            n_cmp++; if (o_rdy !== 1'b0) begin $display("FAIL w3_rd1_wait%0d got rdy=%b want 0", i, o_rdy); n_bad++; end
        end
        idle(32'h0);
        n_cmp++; if ({o_rdy, o_rdata} !== {1'b1, 32'h2222_2222}) begin
            $display("FAIL w3_rd1_done got rdy=%b rdata=%h want 1 22222222", o_rdy, o_rdata); n_bad++; end
    endtask

    task automatic test_reset_mid;
        sel3 = 1'b1;
        step(1'b0, 1'b1, 32'h4, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        idle(32'h0);
        n_cmp++; if (o_rdy !== 1'b0) begin $display("FAIL mid_wait got rdy=%b want 0", o_rdy); n_bad++; end
        step(1'b1, 1'b0, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        idle(32'h0);
        n_cmp++; if ({o_rdy, o_cs, o_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            $display("FAIL mid_rst got rdy=%b cs=%b rdata=%h want 1 0 0", o_rdy, o_cs, o_rdata); n_bad++; end
        step(1'b0, 1'b1, 32'h0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        for (int i = 0; i < 3; i++) idle(32'h0);
        idle(32'h0);
        n_cmp++; if ({o_rdy, o_resp, o_rdata} !== {1'b1, 1'b0, 32'h1111_1111}) begin
            $display("FAIL mid_after got rdy=%b resp=%b rdata=%h want 1 0 11111111", o_rdy, o_resp, o_rdata); n_bad++; end
        sel3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_errors();
        test_burst();
        test_rd_wait3();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
